// File: rtl/fpga_mem_responder.sv
// Line-oriented memory responder: 8-word read bursts after a fixed latency, 8-word writes with acknowledge.
// Optional sticky protocol-error flag enabled by defining FPGA_MEM_RESP_ERR_EN.
module fpga_mem_responder #(
  parameter int MEM_WORDS  = 4096,
  parameter int RD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address_data_bus_c_to_m,
  input  logic        address_on_c_to_m,
  input  logic        data_on_c_to_m,
  input  logic        read_en_c_to_m,
  input  logic        write_en_c_to_m,
  output logic [31:0] address_data_bus_m_to_c,
  output logic        resp_m_to_c,
`ifdef FPGA_MEM_RESP_ERR_EN
  output logic        proto_err,
`endif
  output logic [2:0]  dbg_state_o
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int LW = AW - 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_BURST = 3'd2,
    WR_DATA  = 3'd3,
    WR_ACK   = 3'd4
  } state_t;

  state_t          state_q;
  logic [LW-1:0]   base_q;
  logic [3:0]      beat_q;
  logic [3:0]      lat_q;
  logic [31:0]     rdata_q;
  logic            resp_q;

  logic [31:0]     mem [MEM_WORDS];

  logic            req_rd;
  logic            req_wr;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [LW-1:0]   line_in;

  // Handshake: a request is one address_on cycle in IDLE; data beats are qualified by data_on;
  // resp_m_to_c marks each read beat and the single write acknowledge, with no back-pressure.
  assign req_rd   = address_on_c_to_m & read_en_c_to_m & ~write_en_c_to_m;
  assign req_wr   = address_on_c_to_m & write_en_c_to_m & ~read_en_c_to_m;
  assign line_in  = address_data_bus_c_to_m[AW+1:5];
  assign mem_addr = {base_q, beat_q[2:0]};
  assign mem_we   = (state_q == WR_DATA) && data_on_c_to_m;

  // Backing store has no reset so contents survive an aborted transaction.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= address_data_bus_c_to_m;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      beat_q  <= 4'd0;
      lat_q   <= 4'd0;
      rdata_q <= 32'd0;
      resp_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rdata_q <= 32'd0;
          resp_q  <= 1'b0;
          beat_q  <= 4'd0;
          if (req_rd) begin
            base_q  <= line_in;
            lat_q   <= 4'(RD_LATENCY - 1);
            state_q <= RD_WAIT;
          end else if (req_wr) begin
            base_q  <= line_in;
            state_q <= WR_DATA;
          end
        end
        RD_WAIT: begin
          // The first beat is registered on the edge where the countdown hits zero.
          if (lat_q == 4'd0) begin
            rdata_q <= mem[mem_addr];
            resp_q  <= 1'b1;
            beat_q  <= 4'd1;
            state_q <= RD_BURST;
          end else begin
            lat_q <= lat_q - 4'd1;
          end
        end
        RD_BURST: begin
          if (beat_q == 4'd8) begin
            rdata_q <= 32'd0;
            resp_q  <= 1'b0;
            beat_q  <= 4'd0;
            state_q <= IDLE;
          end else begin
            rdata_q <= mem[mem_addr];
            resp_q  <= 1'b1;
            beat_q  <= beat_q + 4'd1;
          end
        end
        WR_DATA: begin
          if (data_on_c_to_m) begin
            if (beat_q == 4'd7) begin
              beat_q  <= 4'd0;
              resp_q  <= 1'b1;
              state_q <= WR_ACK;
            end else begin
              beat_q <= beat_q + 4'd1;
            end
          end
        end
        WR_ACK: begin
          resp_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          rdata_q <= 32'd0;
          resp_q  <= 1'b0;
          beat_q  <= 4'd0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign address_data_bus_m_to_c = rdata_q;
  assign resp_m_to_c             = resp_q;
  assign dbg_state_o             = state_q;

`ifdef FPGA_MEM_RESP_ERR_EN
  logic err_q;
  logic err_d;

  always_comb begin
    err_d = err_q;
    if (address_on_c_to_m && ((state_q != IDLE) || (read_en_c_to_m == write_en_c_to_m)))
      err_d = 1'b1;
    if (data_on_c_to_m && ((state_q == IDLE) || (state_q == RD_WAIT) || (state_q == RD_BURST)))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign proto_err = err_q;
`endif

endmodule

// File: tb/tb_fpga_mem_responder.sv
// Directed bench for fpga_mem_responder: line writes, gapped writes, wrap, illegal requests,
// busy overlap and reset abort, checked against a small memory model.
module tb_fpga_mem_responder;

  localparam int MEM_WORDS  = 4096;
  localparam int RD_LATENCY = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bus_in = 32'd0;
  logic        address_on = 1'b0;
  logic        data_on = 1'b0;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic [31:0] bus_out;
  logic        resp;
  logic [2:0]  dbg_state;
`ifdef FPGA_MEM_RESP_ERR_EN
  logic        proto_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [MEM_WORDS];

  fpga_mem_responder #(
    .MEM_WORDS (MEM_WORDS),
    .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .address_data_bus_c_to_m(bus_in),
    .address_on_c_to_m      (address_on),
    .data_on_c_to_m         (data_on),
    .read_en_c_to_m         (read_en),
    .write_en_c_to_m        (write_en),
    .address_data_bus_m_to_c(bus_out),
    .resp_m_to_c            (resp),
`ifdef FPGA_MEM_RESP_ERR_EN
    .proto_err              (proto_err),
`endif
    .dbg_state_o            (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int line_idx(input logic [31:0] a);
    logic [31:0] w;
    w = (a >> 2) & 32'(MEM_WORDS - 1) & ~32'd7;
    return int'(w);
  endfunction

  task automatic watch_quiet(input string tag);
    int cnt;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp) cnt++;
    end
    check(tag, cnt, 0);
  endtask

  task automatic write_line(input logic [31:0] addr, input logic [31:0] d[8],
                            input bit gap, input string tag);
    int idx;
    int early;
    idx = line_idx(addr);
    early = 0;
    bus_in = addr; address_on = 1'b1; write_en = 1'b1;
    @(negedge clk);
    address_on = 1'b0; write_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (resp) early++;
      data_on = 1'b1; bus_in = d[i];
      model_mem[idx + i] = d[i];
      @(negedge clk);
      data_on = 1'b0; bus_in = 32'd0;
      if (gap && i < 7) begin
        if (resp) early++;
        @(negedge clk);
      end
    end
    check({tag, "_early_ack"}, early, 0);
    check({tag, "_ack"}, resp, 1'b1);
    check({tag, "_ack_bus"}, bus_out, 32'd0);
    @(negedge clk);
    check({tag, "_ack_one_cycle"}, resp, 1'b0);
  endtask

  // mode 0: plain read, 1: address beat during the burst, 2: reset after three beats
  task automatic read_line(input logic [31:0] addr, input int mode, input string tag);
    int idx;
    int lat;
    int beats;
    logic [31:0] e;
    idx = line_idx(addr);
    for (int i = 0; i < 8; i++) exp_q.push_back(model_mem[idx + i]);
    bus_in = addr; address_on = 1'b1; read_en = 1'b1;
    @(negedge clk);
    address_on = 1'b0; read_en = 1'b0; bus_in = 32'd0;
    lat = 0;
    while (!resp && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, RD_LATENCY);
    beats = 0;
    for (int b = 0; b < 8; b++) begin
      if (mode == 2 && b == 3) break;
      if (mode == 1 && b == 2) begin
        bus_in = addr; address_on = 1'b1; read_en = 1'b1;
      end
      if (resp) beats++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      check($sformatf("%s_beat%0d", tag, b), bus_out, e);
      @(negedge clk);
      address_on = 1'b0; read_en = 1'b0; bus_in = 32'd0;
    end
    if (mode == 2) begin
      exp_q.delete();
      check({tag, "_beats_before_reset"}, beats, 3);
      rst = 1'b1;
      #1;
      check({tag, "_resp_drop"}, resp, 1'b0);
      check({tag, "_bus_drop"}, bus_out, 32'd0);
      @(negedge clk);
      check({tag, "_state_reset"}, dbg_state, 3'd0);
      rst = 1'b0;
      watch_quiet({tag, "_no_beats_after_reset"});
    end else begin
      check({tag, "_beat_count"}, beats, 8);
      watch_quiet({tag, "_quiet_after"});
    end
  endtask

  initial begin
    logic [31:0] d_plain [8];
    logic [31:0] d_gap   [8];
    logic [31:0] d_wrap  [8];
    for (int i = 0; i < 8; i++) begin
      d_plain[i] = 32'h11111111 * 32'(i + 1);
      d_gap[i]   = 32'hA0000000 + 32'(i);
      d_wrap[i]  = 32'hC0DE0000 + 32'(i * 3);
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_resp", resp, 1'b0);
    check("reset_bus", bus_out, 32'd0);
    check("reset_state", dbg_state, 3'd0);
`ifdef FPGA_MEM_RESP_ERR_EN
    check("reset_proto_err", proto_err, 1'b0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back write then read of one line
    write_line(32'h0000_0100, d_plain, 1'b0, "wr_plain");
    read_line(32'h0000_0100, 0, "rd_plain");

    // Gapped write: ack only after the eighth accepted beat
    write_line(32'h0000_021C, d_gap, 1'b1, "wr_gap");
    read_line(32'h0000_0200, 0, "rd_gap");

    // Address wrap: 0x4100 aliases 0x0100 in a 4096-word store
    write_line(32'h0000_4100, d_wrap, 1'b0, "wr_wrap");
    read_line(32'h0000_0100, 0, "rd_wrap");

    // Both enables high: ignored
    bus_in = 32'h0000_0300; address_on = 1'b1; read_en = 1'b1; write_en = 1'b1;
    @(negedge clk);
    address_on = 1'b0; read_en = 1'b0; write_en = 1'b0; bus_in = 32'd0;
    watch_quiet("illegal_no_resp");
`ifdef FPGA_MEM_RESP_ERR_EN
    check("illegal_proto_err", proto_err, 1'b1);
`endif

    // Address beat while a burst is running
    read_line(32'h0000_0200, 1, "rd_overlap");

    // Reset mid-burst, then confirm memory contents survived
    read_line(32'h0000_0100, 2, "rd_abort");
`ifdef FPGA_MEM_RESP_ERR_EN
    check("abort_proto_err_cleared", proto_err, 1'b0);
`endif

    // Stray data beat in IDLE must not write anything
    data_on = 1'b1; bus_in = 32'hDEADBEEF;
    @(negedge clk);
    data_on = 1'b0; bus_in = 32'd0;
    check("idle_data_no_resp", resp, 1'b0);
`ifdef FPGA_MEM_RESP_ERR_EN
    check("idle_data_proto_err", proto_err, 1'b1);
`endif
    read_line(32'h0000_0100, 0, "rd_after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
